// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } ifu_state_t;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ifu_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Redirect, instruction-memory and decode-side handshakes of the fetch stage.
interface ifu_fetch_if;

   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   modport master (
      input  redirect_valid, redirect_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_ready,
      output imem_req_valid, imem_req_addr,
      output inst_valid, inst_out, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_ready,
      input  imem_req_valid, imem_req_addr,
      input  inst_valid, inst_out, inst_pc
   );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous {pc, inst} buffer; pointers carry an extra MSB to tell full from empty.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  ifu_entry_t push_data,
   input  logic       pop,
   input  logic       flush,
   output logic [AW:0] count,
   output ifu_entry_t head
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   ifu_entry_t  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        do_push;
   logic        do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; the empty mux below hides stale contents.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         assert (!(push && full));
         if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_comb begin
      head      = '0;
      head.inst = INST_NOP;
      if (!empty) head = mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the fetch PC, issues one imem request at a time under a buffer credit.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   ifu_fetch_if.master bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   ifu_state_t  state;
   ifu_state_t  state_next;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pc_next;
   logic [31:0] req_pc;
   logic [31:0] req_pc_next;
   logic        push;
   logic        req_valid;
   logic        pop_fire;
   logic [AW:0] count;
   logic [31:0] count_w;
   logic [31:0] count_after_push;
   logic        credit_now;
   logic        credit_after_push;
   ifu_entry_t  push_entry;
   ifu_entry_t  head;

   assign count_w           = 32'(count);
   assign pop_fire          = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
   assign count_after_push  = count_w + 32'd1 - (pop_fire ? 32'd1 : 32'd0);
   // Outstanding is zero in S_IDLE and becomes zero on the S_WAIT push.
   assign credit_now        = (count_w < FIFO_DEPTH);
   assign credit_after_push = (count_after_push < FIFO_DEPTH);

   assign push_entry.pc   = req_pc;
   assign push_entry.inst = bus.imem_rsp_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         req_pc   <= req_pc_next;
      end
   end

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      req_pc_next   = req_pc;
      push          = 1'b0;
      req_valid     = 1'b0;

      case (state)
         S_IDLE: begin
            if (credit_now) state_next = S_REQ;
         end
         S_REQ: begin
            req_valid = 1'b1;
            if (bus.imem_req_ready) begin
               req_pc_next   = fetch_pc;
               fetch_pc_next = fetch_pc + 32'd4;
               state_next    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rsp_valid) begin
               push       = 1'b1;
               state_next = credit_after_push ? S_REQ : S_IDLE;
            end
         end
         S_DROP: begin
            if (bus.imem_rsp_valid) state_next = S_REQ;
         end
         default: state_next = S_IDLE;
      endcase

      // Redirect overrides the normal transitions; only whether a response is
      // still owed decides between S_REQ and S_DROP.
      if (bus.redirect_valid) begin
         push          = 1'b0;
         fetch_pc_next = word_align(bus.redirect_pc);
         case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ:   state_next = bus.imem_req_ready ? S_DROP : S_REQ;
            S_WAIT:  state_next = bus.imem_rsp_valid ? S_REQ : S_DROP;
            S_DROP:  state_next = bus.imem_rsp_valid ? S_REQ : S_DROP;
            default: state_next = S_REQ;
         endcase
      end
   end

   ifu_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (bus.inst_ready),
      .flush     (bus.redirect_valid),
      .count     (count),
      .head      (head)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.inst_valid     = (count != '0);
   assign bus.inst_out       = head.inst;
   assign bus.inst_pc        = head.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a variable-latency instruction memory model.
module tb_ifu_fetch;

   logic        clk;
   logic        rst;
   int unsigned lat;
   int unsigned n_checks;
   int unsigned n_fail;

   logic [31:0] req_q [$];
   logic [31:0] del_q [$];
   logic [31:0] del_d [$];
   int unsigned del_cyc [$];
   int unsigned cyc;

   ifu_fetch_if bus ();

   ifu_fetch #(
      .RESET_PC   (32'h8000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q [$], input int unsigned i);
      return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory: one response per accepted request, lat cycles later; cleared on rst.
   initial begin
      logic        acc;
      logic        rst_s;
      logic [31:0] a;
      logic        pend;
      logic [31:0] paddr;
      int unsigned cnt;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      pend  = 1'b0;
      paddr = '0;
      cnt   = 0;
      forever begin
         @(negedge clk);
         acc   = bus.imem_req_valid && bus.imem_req_ready;
         a     = bus.imem_req_addr;
         rst_s = rst;
         @(posedge clk);
         #1;
         bus.imem_rsp_valid = 1'b0;
         if (rst_s) begin
            pend = 1'b0;
         end else begin
            if (acc) begin
               pend  = 1'b1;
               paddr = a;
               cnt   = lat;
            end
            if (pend) begin
               if (cnt <= 1) begin
                  bus.imem_rsp_valid = 1'b1;
                  bus.imem_rsp_data  = mem_word(paddr);
                  pend = 1'b0;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // Log accepted requests and decode-side deliveries.
   initial begin
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (bus.imem_req_valid && bus.imem_req_ready)
               req_q.push_back(bus.imem_req_addr);
            if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
               del_q.push_back(bus.inst_pc);
               del_d.push_back(bus.inst_out);
               del_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r0;
      int unsigned d0;
      int unsigned spacing;
      logic        seen;
      logic        stable;
      logic        found;
      logic [31:0] held_out;
      logic [31:0] held_pc;

      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      lat = 1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b0;

      // Reset values
      tick();
      check("rst_req_valid",  32'(bus.imem_req_valid), 32'd0);
      check("rst_req_addr",   bus.imem_req_addr, 32'h8000_0000);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst_out",   bus.inst_out, 32'h0000_0013);
      check("rst_inst_pc",    bus.inst_pc, 32'h0000_0000);

      // Straight-line fetch, 1-cycle memory
      rst = 1'b0;
      bus.inst_ready = 1'b1;
      tick();
      check("t1_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t1_first_req_addr",  bus.imem_req_addr, 32'h8000_0000);
      tick();
      tick();
      check("t1_inst_valid", 32'(bus.inst_valid), 32'd1);
      check("t1_inst_pc",    bus.inst_pc, 32'h8000_0000);
      check("t1_inst_out",   bus.inst_out, mem_word(32'h8000_0000));
      check("t1_next_addr",  bus.imem_req_addr, 32'h8000_0004);
      repeat (6) tick();
      check("t1_req0", qget(req_q, 0), 32'h8000_0000);
      check("t1_req1", qget(req_q, 1), 32'h8000_0004);
      check("t1_req2", qget(req_q, 2), 32'h8000_0008);
      check("t1_del0", qget(del_q, 0), 32'h8000_0000);
      check("t1_del1", qget(del_q, 1), 32'h8000_0004);
      check("t1_del2", qget(del_q, 2), 32'h8000_0008);
      spacing = (del_cyc.size() >= 2) ? del_cyc[1] - del_cyc[0] : 0;
      check("t1_spacing", spacing, 32'd2);

      // Back-pressure from decode
      bus.inst_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      r0 = req_q.size();
      d0 = del_q.size();
      seen = 1'b0;
      stable = 1'b1;
      held_out = '0;
      held_pc = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.inst_valid) begin
            if (!seen) begin
               held_out = bus.inst_out;
               held_pc  = bus.inst_pc;
               seen     = 1'b1;
            end else if (bus.inst_out !== held_out || bus.inst_pc !== held_pc) begin
               stable = 1'b0;
            end
         end
      end
      check("t2_req_count",  req_q.size() - r0, 32'd2);
      check("t2_req_valid",  32'(bus.imem_req_valid), 32'd0);
      check("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
      check("t2_inst_out",   bus.inst_out, mem_word(32'h8000_0000));
      check("t2_stable",     32'(stable), 32'd1);
      bus.inst_ready = 1'b1;
      repeat (10) tick();
      check("t2_del0", qget(del_q, d0),     32'h8000_0000);
      check("t2_del1", qget(del_q, d0 + 1), 32'h8000_0004);
      check("t2_del2", qget(del_q, d0 + 2), 32'h8000_0008);
      check("t2_dat2", qget(del_d, d0 + 2), mem_word(32'h8000_0008));
      check("t2_req2", qget(req_q, r0 + 2), 32'h8000_0008);

      // Redirect while waiting on a 5-cycle memory
      lat = 5;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      r0 = req_q.size();
      d0 = del_q.size();
      tick();
      tick();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0103;
      tick();
      bus.redirect_valid = 1'b0;
      check("t3_drop_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("t3_new_addr",       bus.imem_req_addr, 32'h8000_0100);
      repeat (14) tick();
      check("t3_req_old", qget(req_q, r0),     32'h8000_0000);
      check("t3_req_new", qget(req_q, r0 + 1), 32'h8000_0100);
      check("t3_del_pc",  qget(del_q, d0),     32'h8000_0100);
      check("t3_del_dat", qget(del_d, d0),     mem_word(32'h8000_0100));

      // Redirect colliding with a response while the buffer holds a word
      lat = 1;
      bus.inst_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      d0 = del_q.size();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.imem_rsp_valid && bus.inst_valid) found = 1'b1;
      end
      check("t4_collision_found", 32'(found), 32'd1);
      #1;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0200;
      tick();
      bus.redirect_valid = 1'b0;
      check("t4_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("t4_inst_out",   bus.inst_out, 32'h0000_0013);
      check("t4_req_valid",  32'(bus.imem_req_valid), 32'd1);
      check("t4_req_addr",   bus.imem_req_addr, 32'h8000_0200);
      repeat (6) tick();
      check("t4_first_del", qget(del_q, d0), 32'h8000_0200);

      // Wrap at the top of the address space; low redirect bits ignored
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFF;
      tick();
      bus.redirect_valid = 1'b0;
      r0 = req_q.size();
      d0 = del_q.size();
      check("t5_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      repeat (10) tick();
      check("t5_req0", qget(req_q, r0),     32'hFFFF_FFFC);
      check("t5_req1", qget(req_q, r0 + 1), 32'h0000_0000);
      check("t5_del0", qget(del_q, d0),     32'hFFFF_FFFC);
      check("t5_del1", qget(del_q, d0 + 1), 32'h0000_0000);

      // Reset in the middle of a wait
      lat = 5;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready) found = 1'b1;
      end
      check("t6_accept_found", 32'(found), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      check("t6_req_valid",  32'(bus.imem_req_valid), 32'd0);
      check("t6_req_addr",   bus.imem_req_addr, 32'h8000_0000);
      check("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("t6_inst_out",   bus.inst_out, 32'h0000_0013);
      check("t6_inst_pc",    bus.inst_pc, 32'h0000_0000);
      rst = 1'b0;
      d0 = del_q.size();
      tick();
      check("t6_restart_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t6_restart_addr",  bus.imem_req_addr, 32'h8000_0000);
      repeat (12) tick();
      check("t6_del_pc",  qget(del_q, d0), 32'h8000_0000);
      check("t6_del_dat", qget(del_d, d0), mem_word(32'h8000_0000));

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
